// File: rtl/bi_mem_client.sv
// Request/response client for a single-port synchronous memory. Reads return
// through an in-order response FIFO whose credits gate request acceptance.
module bi_mem_client #(
    parameter int WIDTH     = 16,
    parameter int HEIGHT    = 16,
    parameter int RSP_DEPTH = 3,
    localparam int AW       = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic [AW-1:0]    req_addr_i,
    input  logic [WIDTH-1:0] req_data_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             rsp_err_o,
    output logic             mem_enable_o,
    output logic             mem_writeEnable_o,
    output logic [AW-1:0]    mem_addr_o,
    output logic [WIDTH-1:0] mem_data_o,
    input  logic [WIDTH-1:0] mem_data_i
);

    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(RSP_DEPTH - 1);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             inflight_q, inflight_d;
    logic             inflight_err_q, inflight_err_d;
    logic [WIDTH-1:0] fifo_data_q [RSP_DEPTH];
    logic             fifo_err_q  [RSP_DEPTH];

    logic             accept;
    logic             in_range;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_data;

    always_comb begin
        req_ready_o       = 1'b0;
        accept            = 1'b0;
        in_range          = 1'b0;
        mem_enable_o      = 1'b0;
        mem_writeEnable_o = 1'b0;
        mem_addr_o        = '0;
        mem_data_o        = '0;
        inflight_d        = 1'b0;
        inflight_err_d    = 1'b0;
        push              = 1'b0;
        push_data         = '0;
        pop               = 1'b0;
        wr_ptr_d          = wr_ptr_q;
        rd_ptr_d          = rd_ptr_q;
        count_d           = count_q;
        rsp_valid_o       = 1'b0;
        rsp_data_o        = '0;
        rsp_err_o         = 1'b0;

        // A read accepted last cycle already owns a FIFO slot, so it counts as used.
        req_ready_o = rst_ni && ((32'(count_q) + 32'(inflight_q)) < 32'(RSP_DEPTH));
        accept      = req_valid_i && req_ready_o;
        in_range    = 32'(req_addr_i) < 32'(HEIGHT);

        if (accept && in_range) begin
            mem_enable_o      = 1'b1;
            mem_writeEnable_o = req_write_i;
            mem_addr_o        = req_addr_i;
            mem_data_o        = req_data_i;
        end

        inflight_d     = accept && !req_write_i;
        inflight_err_d = accept && !req_write_i && !in_range;

        push      = inflight_q;
        push_data = inflight_err_q ? '0 : mem_data_i;

        rsp_valid_o = (count_q != '0);
        if (rsp_valid_o) begin
            rsp_data_o = fifo_data_q[rd_ptr_q];
            rsp_err_o  = fifo_err_q[rd_ptr_q];
        end
        pop = rsp_valid_o && rsp_ready_i;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            inflight_q     <= 1'b0;
            inflight_err_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            inflight_q     <= inflight_d;
            inflight_err_q <= inflight_err_d;
        end
    end

    // Payload storage needs no reset: nothing is visible until count_q says so.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= push_data;
            fifo_err_q[wr_ptr_q]  <= inflight_err_q;
        end
    end

endmodule

// File: tb/tb_bi_mem_client.sv
// Scoreboard bench for bi_mem_client: directed requests push expected read
// responses; a negedge monitor pops and compares whatever the DUT returns.
module tb_bi_mem_client;

    localparam int WIDTH     = 16;
    localparam int HEIGHT    = 12;
    localparam int RSP_DEPTH = 3;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i, req_ready_o, req_write_i;
    logic [3:0]  req_addr_i;
    logic [15:0] req_data_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [15:0] rsp_data_o;
    logic        mem_enable_o, mem_writeEnable_o;
    logic [3:0]  mem_addr_o;
    logic [15:0] mem_data_o, mem_data_i;

    always #5 clk_i = ~clk_i;

    bi_mem_client #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_write_i(req_write_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .mem_enable_o(mem_enable_o), .mem_writeEnable_o(mem_writeEnable_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
    );

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    logic       rdy_man;
    logic       pat_en;
    logic [7:0] pat = 8'b1011_0010;
    assign rsp_ready_i = pat_en ? pat[3'(cyc)] : rdy_man;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Memory model: word i preloads to 0xA000+i; read data one cycle after enable.
    logic [15:0] mem [16];
    always @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'hA000 + 16'(i);
            mem_data_i <= '0;
        end else if (mem_enable_o) begin
            if (mem_writeEnable_o) mem[mem_addr_o] <= mem_data_o;
            else                   mem_data_i <= mem[mem_addr_o];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk_i) begin
        if (rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got data %0h err %0b expected no response", rsp_data_o, rsp_err_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_data", 32'(rsp_data_o), 32'(e.data));
                check("rsp_err", 32'(rsp_err_o), 32'(e.err));
                if (e.cyc >= 0) check("rsp_latency", 32'(cyc), 32'(e.cyc));
            end
        end else if (!rsp_valid_o) begin
            check("empty_rsp_data", 32'(rsp_data_o), 0);
            check("empty_rsp_err", 32'(rsp_err_o), 0);
        end
        if (!(req_valid_i && req_ready_o)) begin
            check("idle_mem_en", 32'(mem_enable_o), 0);
            check("idle_mem_we", 32'(mem_writeEnable_o), 0);
            check("idle_mem_addr", 32'(mem_addr_o), 0);
            check("idle_mem_data", 32'(mem_data_o), 0);
        end
    end

    task automatic idle();
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_addr_i  = '0;
        req_data_i  = '0;
    endtask

    task automatic do_req(input logic wr, input logic [3:0] addr, input logic [15:0] data,
                          input logic [15:0] exp_d, input logic exp_e, input logic exact,
                          output logic waited);
        int   n;
        logic done;
        exp_t e;
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_addr_i  = addr;
        req_data_i  = data;
        waited = 1'b0;
        n      = 0;
        done   = 1'b0;
        while (!done) begin
            @(negedge clk_i);
            if (req_ready_o) begin
                if (addr < 4'd12) begin
                    check("acc_mem_en", 32'(mem_enable_o), 1);
                    check("acc_mem_we", 32'(mem_writeEnable_o), 32'(wr));
                    check("acc_mem_addr", 32'(mem_addr_o), 32'(addr));
                    check("acc_mem_data", 32'(mem_data_o), 32'(data));
                end else begin
                    check("oor_mem_en", 32'(mem_enable_o), 0);
                    check("oor_mem_we", 32'(mem_writeEnable_o), 0);
                end
                if (!wr) begin
                    e.data = exp_d;
                    e.err  = exp_e;
                    e.cyc  = exact ? cyc + 2 : -1;
                    exp_q.push_back(e);
                end
                done = 1'b1;
            end else begin
                waited = 1'b1;
                n++;
                if (n >= 50) begin
                    tests++;
                    fails++;
                    $display("FAIL req_accept_timeout: got no accept expected accept within 50 cycles");
                    done = 1'b1;
                end
            end
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk_i);
            n++;
        end
        #1;
        check("drain_left", 32'(exp_q.size()), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready_o), 0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid_o), 0);
        check({tag, "_rsp_data"}, 32'(rsp_data_o), 0);
        check({tag, "_rsp_err"}, 32'(rsp_err_o), 0);
        check({tag, "_mem_en"}, 32'(mem_enable_o), 0);
        check({tag, "_mem_we"}, 32'(mem_writeEnable_o), 0);
        check({tag, "_mem_addr"}, 32'(mem_addr_o), 0);
        check({tag, "_mem_data"}, 32'(mem_data_o), 0);
    endtask

    logic [3:0]  s_addr [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8};
    logic [15:0] s_exp  [8] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003,
                                16'hA004, 16'hA006, 16'hA007, 16'hA008};
    logic [3:0]  p_addr [6] = '{4'd1, 4'd3, 4'd13, 4'd4, 4'd6, 4'd2};
    logic [15:0] p_exp  [6] = '{16'hA001, 16'hA003, 16'h0000, 16'hA004, 16'hA006, 16'h1234};
    logic        p_err  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        logic w;
        rst_ni  = 1'b0;
        rdy_man = 1'b1;
        pat_en  = 1'b0;
        req_valid_i = 1'b1;
        req_write_i = 1'b1;
        req_addr_i  = 4'd3;
        req_data_i  = 16'hFFFF;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_all_zero("reset");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        idle();
        @(negedge clk_i);
        check("ready_after_reset", 32'(req_ready_o), 1);
        @(posedge clk_i);
        #1;

        // Write then read back.
        do_req(1'b1, 4'd5, 16'hBEEF, 16'h0, 1'b0, 1'b1, w);
        do_req(1'b0, 4'd5, 16'h0, 16'hBEEF, 1'b0, 1'b1, w);
        idle();
        drain();

        // Back-to-back reads with the consumer always ready.
        for (int i = 0; i < 8; i++) begin
            do_req(1'b0, s_addr[i], 16'h0, s_exp[i], 1'b0, 1'b1, w);
            check("stream_waited", 32'(w), 0);
        end
        idle();
        drain();

        // Backpressure: three reads fill the credits, the fourth must stall.
        rdy_man = 1'b0;
        do_req(1'b0, 4'd9,  16'h0, 16'hA009, 1'b0, 1'b0, w);
        do_req(1'b0, 4'd10, 16'h0, 16'hA00A, 1'b0, 1'b0, w);
        do_req(1'b0, 4'd11, 16'h0, 16'hA00B, 1'b0, 1'b0, w);
        check("bp_third_waited", 32'(w), 0);
        req_valid_i = 1'b1;
        req_addr_i  = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("bp_ready_low", 32'(req_ready_o), 0);
            @(posedge clk_i);
            #1;
        end
        rdy_man = 1'b1;
        do_req(1'b0, 4'd0, 16'h0, 16'hA000, 1'b0, 1'b0, w);
        check("bp_fourth_waited", 32'(w), 1);
        idle();
        drain();
        @(negedge clk_i);
        check("bp_ready_back", 32'(req_ready_o), 1);
        @(posedge clk_i);
        #1;

        // Out-of-range read and write, plus in-range write/read around them.
        do_req(1'b0, 4'd13, 16'h0, 16'h0000, 1'b1, 1'b1, w);
        do_req(1'b1, 4'd14, 16'h5555, 16'h0, 1'b0, 1'b1, w);
        do_req(1'b1, 4'd2, 16'h1234, 16'h0, 1'b0, 1'b1, w);
        do_req(1'b0, 4'd2, 16'h0, 16'h1234, 1'b0, 1'b1, w);
        do_req(1'b0, 4'd11, 16'h0, 16'hA00B, 1'b0, 1'b1, w);
        idle();
        drain();

        // Irregular consumer: simultaneous push/pop and stalls in one stream.
        pat_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_req(1'b0, p_addr[i], 16'h0, p_exp[i], p_err[i], 1'b0, w);
        end
        idle();
        drain();
        pat_en = 1'b0;

        // Reset with two queued responses and one read in flight.
        rdy_man = 1'b0;
        do_req(1'b0, 4'd0, 16'h0, 16'hA000, 1'b0, 1'b0, w);
        do_req(1'b0, 4'd1, 16'h0, 16'hA001, 1'b0, 1'b0, w);
        do_req(1'b0, 4'd2, 16'h0, 16'hA002, 1'b0, 1'b0, w);
        check("pre_rst_valid", 32'(rsp_valid_o), 1);
        rst_ni = 1'b0;
        req_valid_i = 1'b1;
        req_addr_i  = 4'd4;
        exp_q.delete();
        #1;
        check_all_zero("midrst");
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        idle();
        rdy_man = 1'b1;
        @(negedge clk_i);
        check("midrst_ready_after", 32'(req_ready_o), 1);
        repeat (10) @(posedge clk_i);
        #1;
        check("midrst_no_rsp", 32'(rsp_valid_o), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
